parsing_bank_loader: RTL and testbench

- Upstream feeder for the layer-00 parsing stage.
- Accepts the feature map as a valid/ready stream of 128-bit words and scatters the words across the 16 dual-port BRAM banks through their write ports.
- Once the last word has been written, issues a one-cycle start pulse to the parsing stage.
- Interleaving is word k → bank k mod NUM_BANKS, address k / NUM_BANKS.

---
 rtl/parsing_pkg.sv | 32 +++
 rtl/parsing_bank_addr_gen.sv | 42 ++++
 rtl/parsing_bank_loader.sv | 140 ++++++++++++++
 tb/tb_parsing_bank_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parsing_pkg.sv
// Shared parameters, loader state encoding and helpers for the layer-00 parsing bank loader.
package parsing_pkg;

  localparam int NUM_BANKS = 16;
  localparam int AW        = 9;
  localparam int DW        = 128;
  localparam int BW        = 4;
  localparam int LW        = AW + BW + 1;

  // Largest legal frame: every word of every bank.
  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_BANKS * (2 ** AW));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    START = 2'd3
  } loader_state_t;

  function automatic logic [NUM_BANKS-1:0] onehot_bank(input logic [BW-1:0] idx);
    onehot_bank      = '0;
    onehot_bank[idx] = 1'b1;
  endfunction

  function automatic logic [31:0] byte_sum(input logic [DW-1:0] w);
    byte_sum = '0;
    for (int i = 0; i < DW / 8; i++) begin
      byte_sum = byte_sum + 32'(w[8*i +: 8]);
    end
  endfunction

endpackage

// File: rtl/parsing_bank_addr_gen.sv
// Word counter for the bank loader: turns word index k into bank one-hot, bank address
// and the last-word flag for the latched frame length.
module parsing_bank_addr_gen
  import parsing_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 adv_i,
  input  logic [LW-1:0]        len_i,
  output logic [NUM_BANKS-1:0] bank_oh_o,
  output logic [AW-1:0]        addr_o,
  output logic                 last_o
);

  logic [LW-2:0] cnt_q, cnt_d;
  logic [LW-1:0] len_m1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // len_i is at least 1 whenever a frame is active, so len-1 never underflows.
  assign len_m1    = len_i - 1'b1;
  assign last_o    = ({1'b0, cnt_q} == len_m1);
  assign bank_oh_o = onehot_bank(cnt_q[BW-1:0]);
  assign addr_o    = cnt_q[AW+BW-1:BW];

endmodule

// File: rtl/parsing_bank_loader.sv
// Scatters a 128-bit word stream across the parsing-stage BRAM banks, then pulses oStart.
// Optional byte checksum output oCksum when PARSING_LOADER_CKSUM_EN is defined.
module parsing_bank_loader
  import parsing_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iLoad,
  input  logic [LW-1:0]        iLen,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_last,
  output logic [NUM_BANKS-1:0] o_ena,
  output logic [NUM_BANKS-1:0] o_wea,
  output logic [AW-1:0]        o_addra,
  output logic [DW-1:0]        o_dia,
  output logic                 oStart,
  output logic                 oBusy,
  output logic                 oErr,
  output logic [1:0]           dbg_state_o
`ifdef PARSING_LOADER_CKSUM_EN
  ,
  output logic [31:0]          oCksum
`endif
);

  loader_state_t        state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 err_q, err_d;
  logic [NUM_BANKS-1:0] ena_q, ena_d;
  logic [AW-1:0]        addra_q, addra_d;
  logic [DW-1:0]        dia_q, dia_d;

  logic                 load_acc;
  logic                 beat;
  logic                 len_ok;
  logic [NUM_BANKS-1:0] bank_oh;
  logic [AW-1:0]        bank_addr;
  logic                 is_last;

  // Handshake: a word transfers on a cycle where s_valid && s_ready; s_ready depends
  // only on state (high throughout LOAD), never on s_valid.
  assign s_ready = (state_q == LOAD);
  assign beat    = s_ready && s_valid;
  assign len_ok  = (iLen != '0) && (iLen <= MAX_LEN);

  parsing_bank_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (load_acc),
    .adv_i     (beat && !is_last),
    .len_i     (len_q),
    .bank_oh_o (bank_oh),
    .addr_o    (bank_addr),
    .last_o    (is_last)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    err_d    = err_q;
    load_acc = 1'b0;
    ena_d    = beat ? bank_oh : '0;
    addra_d  = beat ? bank_addr : addra_q;
    dia_d    = beat ? s_data : dia_q;
    case (state_q)
      IDLE: begin
        if (iLoad) begin
          if (len_ok) begin
            load_acc = 1'b1;
            len_d    = iLen;
            err_d    = 1'b0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // The length decides the end of frame; s_last only matters when it is early.
        if (beat) begin
          if (is_last) begin
            state_d = FLUSH;
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH:   state_d = START;
      START:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      err_q   <= 1'b0;
      ena_q   <= '0;
      addra_q <= '0;
      dia_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      dia_q   <= dia_d;
    end
  end

  assign o_ena       = ena_q;
  assign o_wea       = ena_q;
  assign o_addra     = addra_q;
  assign o_dia       = dia_q;
  assign oStart      = (state_q == START);
  assign oBusy       = (state_q != IDLE);
  assign oErr        = err_q;
  assign dbg_state_o = state_q;

`ifdef PARSING_LOADER_CKSUM_EN
  logic [31:0] cksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_q <= '0;
    end else if (load_acc) begin
      cksum_q <= '0;
    end else if (beat) begin
      cksum_q <= cksum_q + byte_sum(s_data);
    end
  end

  assign oCksum = cksum_q;
`endif

endmodule

// File: tb/tb_parsing_bank_loader.sv
// Bench for parsing_bank_loader: table of frame scenarios plus reset-abort, full-frame and checksum sequences.
module tb_parsing_bank_loader;
  import parsing_pkg::*;

  localparam int EW = BW + AW + DW;

  logic                 clk;
  logic                 rst;
  logic                 iLoad;
  logic [LW-1:0]        iLen;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 s_last;
  logic [NUM_BANKS-1:0] o_ena;
  logic [NUM_BANKS-1:0] o_wea;
  logic [AW-1:0]        o_addra;
  logic [DW-1:0]        o_dia;
  logic                 oStart;
  logic                 oBusy;
  logic                 oErr;
  logic [1:0]           dbg_state;
`ifdef PARSING_LOADER_CKSUM_EN
  logic [31:0]          oCksum;
`endif

  parsing_bank_loader dut (
    .clk         (clk),
    .rst         (rst),
    .iLoad       (iLoad),
    .iLen        (iLen),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .o_ena       (o_ena),
    .o_wea       (o_wea),
    .o_addra     (o_addra),
    .o_dia       (o_dia),
    .oStart      (oStart),
    .oBusy       (oBusy),
    .oErr        (oErr),
    .dbg_state_o (dbg_state)
`ifdef PARSING_LOADER_CKSUM_EN
    ,
    .oCksum      (oCksum)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [EW-1:0]        exp_q[$];
  int                   n_checks = 0;
  int                   n_errors = 0;
  int                   writes = 0;
  int                   starts = 0;
  int                   start_cyc = -1;
  logic [NUM_BANKS-1:0] last_wea = '0;
  logic [AW-1:0]        last_addr = '0;
  bit                   pat_ones = 1'b0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [7:0] b;
    b = pat_ones ? 8'h01 : k[7:0];
    return {16{b}};
  endfunction

  // write monitor: every expected write must appear in order, nothing else may write
  always @(negedge clk) begin
    logic [EW-1:0]        e;
    logic [NUM_BANKS-1:0] oh;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      oh = NUM_BANKS'(1) << e[EW-1 -: BW];
      check("write", {o_ena, o_wea, o_addra, o_dia}, {oh, oh, e[DW +: AW], e[DW-1:0]});
    end else if (o_wea != '0 || o_ena != '0) begin
      check("spurious_write", {o_ena, o_wea}, '0);
    end
    if (o_wea != '0) begin
      writes++;
      last_wea  = o_wea;
      last_addr = o_addra;
    end
    if (oStart) begin
      starts++;
      start_cyc = cyc;
    end
  end

  // driver tasks
  task automatic load_req(input int len);
    @(posedge clk); #1;
    iLoad = 1'b1;
    iLen  = LW'(len);
    @(posedge clk); #1;
    iLoad = 1'b0;
  endtask

  task automatic illegal_load(input int len);
    writes = 0;
    load_req(len);
    @(negedge clk);
    check("illegal_err", oErr, 1'b1);
    check("illegal_ready", s_ready, 1'b0);
    check("illegal_busy", oBusy, 1'b0);
    repeat (3) @(negedge clk);
    check("illegal_no_write", writes, 0);
    check("illegal_ready_hold", s_ready, 1'b0);
  endtask

  task automatic run_frame(input int len, input int gap, input int last_at, input int abort_at,
                           input bit exp_err, input bit exp_start);
    int k, prev_k, nbeats, last_cyc, budget;
    bit acc;
    writes    = 0;
    starts    = 0;
    start_cyc = -1;
    last_cyc  = 0;
    prev_k    = 0;
    load_req(len);
    @(negedge clk);
    check("load_busy", oBusy, 1'b1);
    check("load_err_clear", oErr, 1'b0);
    nbeats = (last_at >= 0) ? last_at + 1 : len;
    acc    = 1'b0;
    k      = 0;
    budget = 0;
    forever begin
      @(posedge clk); #1;
      if (acc) exp_q.push_back({prev_k[BW-1:0], prev_k[AW+BW-1:BW], pat(prev_k)});
      acc = 1'b0;
      if (k == nbeats) break;
      if (k == abort_at) begin
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = pat(k);
        break;
      end
      if (budget > 30000) begin
        check("frame_timeout", k, nbeats);
        break;
      end
      budget++;
      s_valid = ($urandom_range(0, 99) >= gap);
      s_data  = pat(k);
      s_last  = (k == nbeats - 1);
      @(negedge clk);
      check("s_ready_load", s_ready, 1'b1);
      if (s_valid) begin
        acc      = 1'b1;
        prev_k   = k;
        k++;
        last_cyc = cyc;
      end
    end
    if (abort_at >= 0 && rst) begin
      @(negedge clk);
      @(posedge clk); #1;
      rst     = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(negedge clk);
      check("abort_outputs_zero",
            {o_ena, o_wea, o_addra, o_dia, oStart, oBusy, oErr, s_ready}, '0);
      repeat (4) @(negedge clk);
      check("abort_write_count", writes, abort_at);
      check("abort_no_start", starts, 0);
      return;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    check("s_ready_drop", s_ready, 1'b0);
    check("busy_after_last", oBusy, !exp_err);
    repeat (4) @(negedge clk);
    check("write_count", writes, nbeats);
    check("start_count", starts, exp_start);
    check("err_flag", oErr, exp_err);
    check("idle_after", oBusy, 1'b0);
    check("sb_empty", exp_q.size(), 0);
    if (exp_start) check("start_latency", start_cyc, last_cyc + 2);
  endtask

  typedef struct {
    int len;
    int gap;
    int last_at;
    bit legal;
    bit exp_err;
    bit exp_start;
  } vec_t;

  initial begin
    vec_t vecs[9];
    vecs[0] = '{len: 32,   gap: 0,  last_at: -1, legal: 1, exp_err: 0, exp_start: 1};
    vecs[1] = '{len: 20,   gap: 40, last_at: -1, legal: 1, exp_err: 0, exp_start: 1};
    vecs[2] = '{len: 16,   gap: 0,  last_at: 9,  legal: 1, exp_err: 1, exp_start: 0};
    vecs[3] = '{len: 5,    gap: 0,  last_at: -1, legal: 1, exp_err: 0, exp_start: 1};
    vecs[4] = '{len: 0,    gap: 0,  last_at: -1, legal: 0, exp_err: 1, exp_start: 0};
    vecs[5] = '{len: 8193, gap: 0,  last_at: -1, legal: 0, exp_err: 1, exp_start: 0};
    vecs[6] = '{len: 1,    gap: 0,  last_at: -1, legal: 1, exp_err: 0, exp_start: 1};
    vecs[7] = '{len: 17,   gap: 30, last_at: -1, legal: 1, exp_err: 0, exp_start: 1};
    vecs[8] = '{len: 8,    gap: 0,  last_at: 7,  legal: 1, exp_err: 0, exp_start: 1};

    rst     = 1'b1;
    iLoad   = 1'b0;
    iLen    = '0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_ena, o_wea, o_addra, o_dia, oStart, oBusy, oErr, s_ready}, '0);
`ifdef PARSING_LOADER_CKSUM_EN
    check("reset_cksum", oCksum, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].legal) begin
        run_frame(vecs[i].len, vecs[i].gap, vecs[i].last_at, -1, vecs[i].exp_err, vecs[i].exp_start);
      end else begin
        illegal_load(vecs[i].len);
      end
    end

    // reset lands on beat 100 of a full-size frame
    run_frame(8192, 0, -1, 100, 1'b0, 1'b0);

    // full-size frame must end in the top word of the last bank
    run_frame(8192, 0, -1, -1, 1'b0, 1'b1);
    check("max_last_bank", last_wea, 16'h8000);
    check("max_last_addr", last_addr, 9'd511);

`ifdef PARSING_LOADER_CKSUM_EN
    pat_ones = 1'b1;
    run_frame(4, 0, -1, -1, 1'b0, 1'b1);
    check("cksum_after_start", oCksum, 32'd64);
    pat_ones = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
